// File: rtl/receiver.sv
// Serial-to-parallel receive unit for the router link.
// Deframes start / payload (MSB first) / parity / stop frames sampled on Clk_S,
// checks parity and stop bit, and presents good words through a single-entry
// holding register with a valid/accept handshake.
module receiver #(
    parameter int DATA_W     = 55,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              Clk_S,
    input  logic              Rst,
    input  logic              S_Data,
    input  logic              RX_Accept,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Data_Valid,
    output logic              Parity_Err,
    output logic              Frame_Err,
    output logic              Overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] data_next;
    logic              parity_bit;
    logic              parity_next;
    logic              valid_next;
    logic              perr_next;
    logic              ferr_next;
    logic              ovr_next;
    logic              parity_ok;

    // The parity bit is already captured when STOP is evaluated, so the check is a plain compare.
    assign parity_ok = (parity_bit == ((^shreg) ^ ODD_PARITY));

    // Frame FSM state register; reset lands in RESYNC so a line stuck low is never taken as a start bit.
    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            state <= RESYNC;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: bit counter, shift register, captured parity, holding buffer and error pulses.
    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            cnt           <= '0;
            shreg         <= '0;
            parity_bit    <= 1'b0;
            RX_Data       <= '0;
            RX_Data_Valid <= 1'b0;
            Parity_Err    <= 1'b0;
            Frame_Err     <= 1'b0;
            Overrun       <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            shreg         <= shreg_next;
            parity_bit    <= parity_next;
            RX_Data       <= data_next;
            RX_Data_Valid <= valid_next;
            Parity_Err    <= perr_next;
            Frame_Err     <= ferr_next;
            Overrun       <= ovr_next;
        end
    end

    // Next-state and datapath decode; a good word loading on the stop edge overrides a same-cycle accept.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shreg_next  = shreg;
        parity_next = parity_bit;
        data_next   = RX_Data;
        valid_next  = RX_Data_Valid;
        perr_next   = 1'b0;
        ferr_next   = 1'b0;
        ovr_next    = 1'b0;

        if (RX_Accept && RX_Data_Valid) begin
            valid_next = 1'b0;
        end

        case (state)
            RESYNC: begin
                if (S_Data) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!S_Data) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                shreg_next = {shreg[DATA_W-2:0], S_Data};
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST_BIT) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                parity_next = S_Data;
                state_next  = STOP;
            end
            STOP: begin
                if (!S_Data) begin
                    ferr_next  = 1'b1;
                    state_next = RESYNC;
                end else if (!parity_ok) begin
                    perr_next  = 1'b1;
                    state_next = IDLE;
                end else if (!RX_Data_Valid || RX_Accept) begin
                    data_next  = shreg;
                    valid_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    ovr_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = RESYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed frames followed by randomized frames,
// compared every cycle against a frame-level reference model of the holding buffer.
module tb_receiver;

    localparam int DATA_W = 55;
    localparam bit ODD    = 1'b0;

    logic              Clk_S;
    logic              Rst;
    logic              S_Data;
    logic              RX_Accept;
    logic [DATA_W-1:0] RX_Data;
    logic              RX_Data_Valid;
    logic              Parity_Err;
    logic              Frame_Err;
    logic              Overrun;

    int assert_count;
    int fail_count;

    logic [DATA_W-1:0] ref_data;
    logic              ref_valid;
    logic              ref_perr;
    logic              ref_ferr;
    logic              ref_ovr;

    logic [DATA_W-1:0] cur_pay;
    logic              cur_par;

    receiver #(
        .DATA_W    (DATA_W),
        .ODD_PARITY(ODD)
    ) dut (
        .Clk_S        (Clk_S),
        .Rst          (Rst),
        .S_Data       (S_Data),
        .RX_Accept    (RX_Accept),
        .RX_Data      (RX_Data),
        .RX_Data_Valid(RX_Data_Valid),
        .Parity_Err   (Parity_Err),
        .Frame_Err    (Frame_Err),
        .Overrun      (Overrun)
    );

    // Free-running serial clock, 10 ns period.
    initial begin
        Clk_S = 1'b0;
        forever #5 Clk_S = ~Clk_S;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag);
        assert_count++;
        assert (RX_Data === ref_data) else begin
            fail_count++;
            $error("[TB] FAIL %s rx_data observed=%h expected=%h", tag, RX_Data, ref_data);
        end
        assert_count++;
        assert (RX_Data_Valid === ref_valid) else begin
            fail_count++;
            $error("[TB] FAIL %s rx_data_valid observed=%b expected=%b", tag, RX_Data_Valid, ref_valid);
        end
        assert_count++;
        assert (Parity_Err === ref_perr) else begin
            fail_count++;
            $error("[TB] FAIL %s parity_err observed=%b expected=%b", tag, Parity_Err, ref_perr);
        end
        assert_count++;
        assert (Frame_Err === ref_ferr) else begin
            fail_count++;
            $error("[TB] FAIL %s frame_err observed=%b expected=%b", tag, Frame_Err, ref_ferr);
        end
        assert_count++;
        assert (Overrun === ref_ovr) else begin
            fail_count++;
            $error("[TB] FAIL %s overrun observed=%b expected=%b", tag, Overrun, ref_ovr);
        end
    endtask

    // One serial bit: drive on the falling edge, update the model at the rising edge, check 1 ns later.
    task automatic driveEdge(input logic sd, input logic acc, input logic is_stop, input string tag);
        logic good;
        @(negedge Clk_S);
        S_Data    = sd;
        RX_Accept = acc;
        @(posedge Clk_S);
        ref_perr = 1'b0;
        ref_ferr = 1'b0;
        ref_ovr  = 1'b0;
        if (is_stop) begin
            good = sd && (cur_par == ((^cur_pay) ^ ODD));
            if (!sd) begin
                ref_ferr = 1'b1;
            end else if (!good) begin
                ref_perr = 1'b1;
            end
            if (good && (!ref_valid || acc)) begin
                ref_data  = cur_pay;
                ref_valid = 1'b1;
            end else if (good) begin
                ref_ovr = 1'b1;
            end else if (acc) begin
                ref_valid = 1'b0;
            end
        end else if (acc) begin
            ref_valid = 1'b0;
        end
        #1;
        checkOutput(tag);
    endtask

    // Whole frame: start, payload MSB first, parity (optionally corrupted), stop with optional accept.
    task automatic applyStimulus(input logic [DATA_W-1:0] pay, input logic flip_par,
                                 input logic stop_val, input logic acc_stop, input string tag);
        cur_pay = pay;
        cur_par = (^pay) ^ ODD ^ flip_par;
        driveEdge(1'b0, 1'b0, 1'b0, tag);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            driveEdge(pay[i], 1'b0, 1'b0, tag);
        end
        driveEdge(cur_par, 1'b0, 1'b0, tag);
        driveEdge(stop_val, acc_stop, 1'b1, tag);
    endtask

    initial begin
        logic [63:0]       wide;
        logic [DATA_W-1:0] word1;
        logic [DATA_W-1:0] pay;
        logic              flip;
        logic              stopv;
        logic              last_ferr;
        int                gap;

        assert_count = 0;
        fail_count   = 0;
        ref_data     = '0;
        ref_valid    = 1'b0;
        ref_perr     = 1'b0;
        ref_ferr     = 1'b0;
        ref_ovr      = 1'b0;
        cur_pay      = '0;
        cur_par      = 1'b0;
        Rst          = 1'b1;
        S_Data       = 1'b1;
        RX_Accept    = 1'b0;

        // Reset state
        #3;
        checkOutput("reset");
        @(negedge Clk_S);
        @(negedge Clk_S);
        Rst = 1'b0;

        // Test 1: good frame after two idle-high cycles; bit 55 of the literal lies outside the payload
        wide  = 64'h0AB_CDEF_0123_4567;
        word1 = wide[DATA_W-1:0];
        driveEdge(1'b1, 1'b0, 1'b0, "t1_idle");
        driveEdge(1'b1, 1'b0, 1'b0, "t1_idle");
        applyStimulus(word1, 1'b0, 1'b1, 1'b0, "t1_good");

        // Test 2: consume the word, then the same word with a flipped parity bit
        driveEdge(1'b1, 1'b1, 1'b0, "t2_accept");
        applyStimulus(word1, 1'b1, 1'b1, 1'b0, "t2_parity");

        // Test 3: stop bit low, line held low, then high, then a good frame
        applyStimulus(55'h12_3456_789A_BCDE, 1'b0, 1'b0, 1'b0, "t3_frame");
        for (int i = 0; i < 5; i++) begin
            driveEdge(1'b0, 1'b0, 1'b0, "t3_low");
        end
        driveEdge(1'b1, 1'b0, 1'b0, "t3_high");
        applyStimulus(55'h7F_0000_FFFF_0001, 1'b0, 1'b1, 1'b0, "t3_good");

        // Test 4: two back-to-back good frames, no accept -> overrun, first word kept
        driveEdge(1'b1, 1'b1, 1'b0, "t4_accept");
        applyStimulus(55'h55_5555_5555_5555, 1'b0, 1'b1, 1'b0, "t4_first");
        applyStimulus(55'h2A_AAAA_AAAA_AAAA, 1'b0, 1'b1, 1'b0, "t4_second");

        // Test 5: back-to-back, accept on the second stop edge -> second word loads, valid stays
        driveEdge(1'b1, 1'b1, 1'b0, "t5_accept");
        applyStimulus(55'h01_0203_0405_0607, 1'b0, 1'b1, 1'b0, "t5_first");
        applyStimulus(55'h70_6050_4030_2010, 1'b0, 1'b1, 1'b1, "t5_second");

        // Test 6: reset at payload bit 20 while a word is held
        pay     = 55'h3C_3C3C_C3C3_5A5A;
        cur_pay = pay;
        cur_par = (^pay) ^ ODD;
        driveEdge(1'b0, 1'b0, 1'b0, "t6_start");
        for (int i = DATA_W - 1; i > DATA_W - 1 - 20; i--) begin
            driveEdge(pay[i], 1'b0, 1'b0, "t6_payload");
        end
        @(negedge Clk_S);
        Rst = 1'b1;
        #1;
        ref_data  = '0;
        ref_valid = 1'b0;
        ref_perr  = 1'b0;
        ref_ferr  = 1'b0;
        ref_ovr   = 1'b0;
        checkOutput("t6_reset");
        @(negedge Clk_S);
        S_Data = 1'b0;
        Rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveEdge(1'b0, 1'b0, 1'b0, "t6_low");
        end
        driveEdge(1'b1, 1'b0, 1'b0, "t6_high");
        applyStimulus(pay, 1'b0, 1'b1, 1'b0, "t6_good");

        // Randomized frames with injected parity/stop errors, random gaps and accepts
        last_ferr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            gap = int'($urandom_range(0, 3));
            if (last_ferr && gap == 0) begin
                gap = 1;
            end
            for (int g = 0; g < gap; g++) begin
                driveEdge(1'b1, ($urandom_range(0, 2) == 0), 1'b0, "rnd_gap");
            end
            pay   = DATA_W'({$urandom(), $urandom()});
            flip  = ($urandom_range(0, 5) == 0);
            stopv = ($urandom_range(0, 7) != 0);
            applyStimulus(pay, flip, stopv, 1'($urandom_range(0, 1)), "rnd_frame");
            last_ferr = !stopv;
        end
        driveEdge(1'b1, 1'b0, 1'b0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
